// File: rtl/switch_debounce2.sv
// ---------------------------------------------------------------------------
// switch_debounce2
//
// Two-channel switch conditioner. Each raw, asynchronous, bouncy level
// (SW_A, SW_B) goes through a two-flop synchroniser. A small IDLE/CHECK
// state machine with a stability counter then debounces it. The output only
// takes a new level after STABLE_CYCLES+1 consecutive synchronised samples
// have all differed from the current output. A registered one-cycle strobe
// marks every output update. The two channels share nothing except clock
// and reset.
//
// Handshake: none. The outputs are plain levels and strobes. A and B are
// valid in every cycle. A_CHG/B_CHG are high for exactly the one cycle after
// the edge on which A/B took a new value.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous, active-high reset
//   SW_A, SW_B   in   raw switch levels, asynchronous to clk
//   A, B         out  debounced levels
//   A_CHG, B_CHG out  one-cycle change strobes
//   dbg_state_o  out  per-channel FSM state, bit0 = A, bit1 = B
//                     (1 = CHECK, 0 = IDLE)
//
// Parameters:
//   STABLE_CYCLES  >= 1. Sets the qualification length.
//   CNT_W          counter width. 2**CNT_W must be > STABLE_CYCLES.
// ---------------------------------------------------------------------------
module switch_debounce2 #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SW_A,
    input  logic       SW_B,
    output logic       A,
    output logic       B,
    output logic       A_CHG,
    output logic       B_CHG,
    output logic [1:0] dbg_state_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_e;

    // The last count value of a qualification window. cnt_q never goes
    // past this value, so the counter cannot wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Channel index 0 = A, 1 = B throughout.
    logic [1:0]       s1_q;
    logic [1:0]       s2_q;
    logic [1:0]       out_q;
    logic [1:0]       chg_q;
    state_e           state_q [2];
    logic [CNT_W-1:0] cnt_q   [2];

    // Two-flop synchroniser. Only s2_q is used by the debounce logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 2'b00;
            s2_q <= 2'b00;
        end else begin
            s1_q <= {SW_B, SW_A};
            s2_q <= s1_q;
        end
    end

    // Per-channel debounce FSM. The output and the strobe are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= 2'b00;
            chg_q <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                // The strobe lasts one cycle unless an update re-arms it below.
                chg_q[i] <= 1'b0;
                case (state_q[i])
                    IDLE: begin
                        if (s2_q[i] != out_q[i]) begin
                            state_q[i] <= CHECK;
                            cnt_q[i]   <= '0;
                        end
                    end
                    CHECK: begin
                        if (s2_q[i] == out_q[i]) begin
                            // The level bounced back. Drop this attempt
                            // without touching the output.
                            state_q[i] <= IDLE;
                            cnt_q[i]   <= '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            out_q[i]   <= s2_q[i];
                            chg_q[i]   <= 1'b1;
                            state_q[i] <= IDLE;
                            cnt_q[i]   <= '0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        state_q[i] <= IDLE;
                        cnt_q[i]   <= '0;
                    end
                endcase
            end
        end
    end

    assign A              = out_q[0];
    assign B              = out_q[1];
    assign A_CHG          = chg_q[0];
    assign B_CHG          = chg_q[1];
    assign dbg_state_o[0] = (state_q[0] == CHECK);
    assign dbg_state_o[1] = (state_q[1] == CHECK);

endmodule

// File: tb/tb_switch_debounce2.sv
// ---------------------------------------------------------------------------
// tb_switch_debounce2
//
// Bench for switch_debounce2. It runs two instances: the default
// STABLE_CYCLES=4 and a STABLE_CYCLES=1 instance. Both share the same
// switch inputs.
// A reference model states the debounce rule directly: an output takes a
// new level once the synchronised input has differed from it on
// STABLE_CYCLES+1 consecutive edges. The synchronised input is the raw
// input delayed by two edges. The model is checked on every edge.
// Tables of vectors and hand-written sequences add expectations written
// out directly from the intended timing.
// ---------------------------------------------------------------------------
module tb_switch_debounce2;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       sw_a = 1'b0;
    logic       sw_b = 1'b0;
    logic       a0, b0, ca0, cb0;
    logic       a1, b1, ca1, cb1;
    logic [1:0] dbg0, dbg1;

    int total = 0;
    int bad   = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    switch_debounce2 #(.STABLE_CYCLES(4), .CNT_W(20)) dut (
        .clk(clk), .rst(rst), .SW_A(sw_a), .SW_B(sw_b),
        .A(a0), .B(b0), .A_CHG(ca0), .B_CHG(cb0), .dbg_state_o(dbg0)
    );

    switch_debounce2 #(.STABLE_CYCLES(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .SW_A(sw_a), .SW_B(sw_b),
        .A(a1), .B(b1), .A_CHG(ca1), .B_CHG(cb1), .dbg_state_o(dbg1)
    );

    // ---------------- checker ----------------
    function automatic void check(string name, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // Index [d][c]: d = instance (0 for S=4, 1 for S=1), c = channel (0 A, 1 B).
    int   stab [2] = '{4, 1};
    logic m_d1 [2];
    logic m_d2 [2];
    logic m_out[2][2];
    logic m_chg[2][2];
    int   m_run[2][2];

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_d1[c] = 1'b0;
            m_d2[c] = 1'b0;
            for (int d = 0; d < 2; d++) begin
                m_out[d][c] = 1'b0;
                m_chg[d][c] = 1'b0;
                m_run[d][c] = 0;
            end
        end
    endfunction

    function automatic void model_edge();
        logic v;
        for (int c = 0; c < 2; c++) begin
            // The value judged on this edge is the raw input from two edges ago.
            v       = m_d2[c];
            m_d2[c] = m_d1[c];
            m_d1[c] = (c == 0) ? sw_a : sw_b;
            for (int d = 0; d < 2; d++) begin
                m_chg[d][c] = 1'b0;
                if (v != m_out[d][c]) m_run[d][c]++;
                else                  m_run[d][c] = 0;
                if (m_run[d][c] == stab[d] + 1) begin
                    m_out[d][c] = v;
                    m_chg[d][c] = 1'b1;
                    m_run[d][c] = 0;
                end
            end
        end
    endfunction

    function automatic void check_model();
        check("model_A0",  a0,  m_out[0][0]);
        check("model_B0",  b0,  m_out[0][1]);
        check("model_CA0", ca0, m_chg[0][0]);
        check("model_CB0", cb0, m_chg[0][1]);
        check("model_A1",  a1,  m_out[1][0]);
        check("model_B1",  b1,  m_out[1][1]);
        check("model_CA1", ca1, m_chg[1][0]);
        check("model_CB1", cb1, m_chg[1][1]);
    endfunction

    // ---------------- driver tasks ----------------
    // One clock edge. The inputs were set before this edge. Outputs are
    // sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        sw_a = 1'b0;
        sw_b = 1'b0;
        rst  = 1'b1;
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
        repeat (8) tick();
    endtask

    typedef struct {
        logic sa, sb;
        logic ea, eb, eca, ecb;
    } vec_t;

    vec_t vecs[$];

    task automatic run_table(string name);
        for (int j = 0; j < vecs.size(); j++) begin
            sw_a = vecs[j].sa;
            sw_b = vecs[j].sb;
            tick();
            check($sformatf("%s_A[%0d]",  name, j), a0,  vecs[j].ea);
            check($sformatf("%s_B[%0d]",  name, j), b0,  vecs[j].eb);
            check($sformatf("%s_CA[%0d]", name, j), ca0, vecs[j].eca);
            check($sformatf("%s_CB[%0d]", name, j), cb0, vecs[j].ecb);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] seq[5];
        logic [1:0] e_now, e_prev, in_now;
        int         hold[2];
        logic       bit_v;
        vec_t       v;

        model_reset();

        // Reset state.
        #2;
        check("rst_A",   a0,   1'b0);
        check("rst_B",   b0,   1'b0);
        check("rst_CA",  ca0,  1'b0);
        check("rst_CB",  cb0,  1'b0);
        check("rst_dbg", dbg0[0], 1'b0);
        check("rst_dbg", dbg0[1], 1'b0);
        do_reset();

        // Step on SW_A. Edge k is j=0. A rises on edge k+6. The strobe is
        // high only in the cycle after k+6.
        vecs.delete();
        for (int j = 0; j < 12; j++) begin
            v = '{sa: 1'b1, sb: 1'b0, ea: (j >= 6), eb: 1'b0, eca: (j == 6), ecb: 1'b0};
            vecs.push_back(v);
        end
        run_table("step_a");

        // Bounce 1,0,1,0, then hold 0. A never leaves 0.
        do_reset();
        vecs.delete();
        for (int j = 0; j < 14; j++) begin
            v = '{sa: (j < 4) ? ((j % 2) == 0) : 1'b0, sb: 1'b0,
                  ea: 1'b0, eb: 1'b0, eca: 1'b0, ecb: 1'b0};
            vecs.push_back(v);
        end
        run_table("bounce_a");

        // Sequence {SW_A,SW_B} = 00,01,10,11,00 with 8-cycle holds.
        // Outputs follow 6 edges later.
        do_reset();
        seq = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        vecs.delete();
        e_prev = 2'b00;
        for (int j = 0; j < 48; j++) begin
            in_now = seq[(j / 8 > 4) ? 4 : j / 8];
            e_now  = (j >= 6) ? seq[((j - 6) / 8 > 4) ? 4 : (j - 6) / 8] : 2'b00;
            v = '{sa: in_now[1], sb: in_now[0], ea: e_now[1], eb: e_now[0],
                  eca: e_now[1] != e_prev[1], ecb: e_now[0] != e_prev[0]};
            vecs.push_back(v);
            e_prev = e_now;
        end
        run_table("seq_ab");

        // SW_B high for 4 cycles is rejected.
        do_reset();
        for (int j = 0; j < 14; j++) begin
            sw_b = (j < 4);
            tick();
            check($sformatf("glitch4_B[%0d]", j),  b0,  1'b0);
            check($sformatf("glitch4_CB[%0d]", j), cb0, 1'b0);
        end
        // A 5-cycle hold is accepted, and B falls 5 cycles after it rises.
        do_reset();
        for (int j = 0; j < 16; j++) begin
            sw_b = (j < 5);
            tick();
            check($sformatf("pulse5_B[%0d]", j),  b0,  (j >= 6 && j < 11));
            check($sformatf("pulse5_CB[%0d]", j), cb0, (j == 6 || j == 11));
            check($sformatf("pulse5_A[%0d]", j),  a0,  1'b0);
        end

        // Asynchronous reset during CHECK, then requalification from scratch.
        do_reset();
        sw_a = 1'b1;
        repeat (3) tick();
        check("pre_rst_dbg", dbg0[0], 1'b1);
        #3 rst = 1'b1;
        model_reset();
        #1;
        check("arst_A",   a0,      1'b0);
        check("arst_CA",  ca0,     1'b0);
        check("arst_dbg", dbg0[0], 1'b0);
        tick();
        rst = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick();
            check($sformatf("requal_A[%0d]", j),  a0,  (j >= 6));
            check($sformatf("requal_CA[%0d]", j), ca0, (j == 6));
        end
        // While A is 1, an asynchronous reset clears it at once.
        #3 rst = 1'b1;
        model_reset();
        #1;
        check("arst_high_A", a0, 1'b0);
        check("arst_high_A1", a1, 1'b0);
        tick();
        rst = 1'b0;

        // The STABLE_CYCLES=1 instance: a step arrives on edge k+3, and a
        // 1-cycle pulse is rejected.
        do_reset();
        sw_a = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tick();
            check($sformatf("s1_step_A[%0d]", j),  a1,  (j >= 3));
            check($sformatf("s1_step_CA[%0d]", j), ca1, (j == 3));
        end
        do_reset();
        for (int j = 0; j < 8; j++) begin
            sw_a = (j == 0);
            tick();
            check($sformatf("s1_pulse_A[%0d]", j), a1, 1'b0);
        end

        // Random hold lengths around the qualification threshold. Both
        // instances are checked against the model on every edge.
        do_reset();
        hold = '{0, 0};
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < 2; c++) begin
                if (hold[c] == 0) begin
                    bit_v   = 1'($urandom_range(0, 1));
                    hold[c] = $urandom_range(1, 8);
                    if (c == 0) sw_a = bit_v;
                    else        sw_b = bit_v;
                end
                hold[c]--;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
